note_period_decoder: RTL

NOTE_PERIOD_DECODER -- requirements
Module: note_period_decoder

---
 rtl/note_pkg.sv | 26 ++
 rtl/note_period_decoder_if.sv | 33 +++
 rtl/note_len_counter.sv | 44 ++++
 rtl/note_period_decoder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg
// Shared definitions for the note decoder and note player: the one-hot-ish
// state encoding that is exposed on the decoder's state port, the default
// counter width, and the operation codes for the length counter.
package note_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // Encodings are visible on the state port, so they are fixed values.
  typedef enum logic [3:0] {
    ST_RESET    = 4'b0000,
    ST_SYNC     = 4'b1000,
    ST_CNT_HIGH = 4'b0100,
    ST_CNT_LOW  = 4'b0010,
    ST_REPORT   = 4'b0001
  } state_e;

  typedef enum logic [2:0] {
    CNT_HOLD,
    CNT_CLEAR,
    CNT_LOAD1,
    CNT_LOAD2,
    CNT_INC
  } cnt_op_e;

endpackage

// File: rtl/note_period_decoder_if.sv
// note_period_decoder_if
// Bundles the square-wave input and the measurement outputs of the decoder.
//   note_in     : square-wave input (driven by master)
//   half_period : last accepted half-period in clk cycles
//   valid       : one-cycle pulse on half_period update
//   mismatch    : one-cycle pulse when high and low lengths differ
//   overflow    : one-cycle pulse when a length exceeds 2^WIDTH-1
//   state       : current decoder state encoding
// master = the side producing note_in, slave = the decoder.
interface note_period_decoder_if
  import note_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             note_in;
  logic [WIDTH-1:0] half_period;
  logic             valid;
  logic             mismatch;
  logic             overflow;
  logic [3:0]       state;

  modport master (
    output note_in,
    input  half_period, valid, mismatch, overflow, state
  );

  modport slave (
    input  note_in,
    output half_period, valid, mismatch, overflow, state
  );

endinterface

// File: rtl/note_len_counter.sv
// note_len_counter
// Saturating length counter used to measure high and low phases.
//   clk    : clock
//   rst    : synchronous active-low reset, clears the count
//   op     : hold / clear / load 1 / load 2 / increment
//   cnt    : current count
//   at_max : count equals 2^WIDTH-1, so a further increment would overflow
module note_len_counter
  import note_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  cnt_op_e          op,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign at_max = (cnt_q == {WIDTH{1'b1}});
  assign cnt    = cnt_q;

  // Increment saturates; the controller turns an increment at max into an
  // overflow event, so the count never wraps silently.
  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      CNT_CLEAR: cnt_d = '0;
      CNT_LOAD1: cnt_d = WIDTH'(1);
      CNT_LOAD2: cnt_d = WIDTH'(2);
      CNT_INC:   if (!at_max) cnt_d = cnt_q + WIDTH'(1);
      default:   cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_period_decoder.sv
// note_period_decoder
// Measures the high and low phase lengths of a square wave in clk cycles and
// reports the half-period when both phases agree.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : slave side of note_period_decoder_if (note_in in; half_period,
//         valid, mismatch, overflow, state out)
module note_period_decoder
  import note_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  note_period_decoder_if.slave        bus
);

  state_e           state_q, state_d;
  logic             note_prev_q, note_prev_d;
  logic [WIDTH-1:0] high_len_q, high_len_d;
  logic [WIDTH-1:0] half_period_q, half_period_d;
  logic             valid_q, valid_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;

  cnt_op_e          cnt_op;
  logic [WIDTH-1:0] cnt;
  logic             cnt_at_max;
  logic             rise;

  note_len_counter #(.WIDTH(WIDTH)) u_len_counter (
    .clk    (clk),
    .rst    (rst),
    .op     (cnt_op),
    .cnt    (cnt),
    .at_max (cnt_at_max)
  );

  assign rise        = bus.note_in & ~note_prev_q;
  assign note_prev_d = bus.note_in;

  // Next-state and pulse logic. The low length is compared straight from the
  // counter on the edge that ends the low phase, so the verdict is registered
  // and visible during REPORT.
  always_comb begin
    state_d       = state_q;
    cnt_op        = CNT_HOLD;
    high_len_d    = high_len_q;
    half_period_d = half_period_q;
    valid_d       = 1'b0;
    mismatch_d    = 1'b0;
    overflow_d    = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_SYNC;
        cnt_op  = CNT_CLEAR;
      end
      ST_SYNC: begin
        if (rise) begin
          state_d = ST_CNT_HIGH;
          cnt_op  = CNT_LOAD1;
        end
      end
      ST_CNT_HIGH: begin
        if (bus.note_in) begin
          if (cnt_at_max) begin
            overflow_d = 1'b1;
            state_d    = ST_SYNC;
            cnt_op     = CNT_CLEAR;
            high_len_d = '0;
          end else begin
            cnt_op = CNT_INC;
          end
        end else begin
          high_len_d = cnt;
          cnt_op     = CNT_LOAD1;
          state_d    = ST_CNT_LOW;
        end
      end
      ST_CNT_LOW: begin
        if (!bus.note_in) begin
          if (cnt_at_max) begin
            overflow_d = 1'b1;
            state_d    = ST_SYNC;
            cnt_op     = CNT_CLEAR;
            high_len_d = '0;
          end else begin
            cnt_op = CNT_INC;
          end
        end else begin
          state_d = ST_REPORT;
          if (high_len_q == cnt) begin
            half_period_d = high_len_q;
            valid_d       = 1'b1;
          end else begin
            mismatch_d = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        // The REPORT cycle itself belongs to the next high phase, which
        // already includes the rising-edge sample, hence a load of 2.
        if (bus.note_in) begin
          state_d = ST_CNT_HIGH;
          cnt_op  = CNT_LOAD2;
        end else begin
          high_len_d = WIDTH'(1);
          cnt_op     = CNT_LOAD1;
          state_d    = ST_CNT_LOW;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_op  = CNT_CLEAR;
      end
    endcase
  end

  // note_prev resets to 1 so a level already high at release is not a rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RESET;
      note_prev_q   <= 1'b1;
      high_len_q    <= '0;
      half_period_q <= '0;
      valid_q       <= 1'b0;
      mismatch_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      note_prev_q   <= note_prev_d;
      high_len_q    <= high_len_d;
      half_period_q <= half_period_d;
      valid_q       <= valid_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.half_period = half_period_q;
  assign bus.valid       = valid_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.overflow    = overflow_q;
  assign bus.state       = state_q;

endmodule
